// File: rtl/hwce_yin_feeder_if.sv
// Bundles the partial-sum memory stream and the shift-adder operand signals
// of hwce_yin_feeder.
//   master : the feeder (accepts memory beats, drives operand and stall)
//   slave  : the environment (memory source and column-engine monitor)
// Signals:
//   mem_y_data/mem_y_valid/mem_y_ready : partial-sum stream, pixel 0 in LSBs
//   valid_y_in_sop                     : monitored column valids
//   y_in/valid_y_in/sum_over_constant  : operand to the shift adder
//   col_stall                          : hold request to the column engines
interface hwce_yin_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_COL      = 4
);
  logic [DATA_WIDTH-1:0] mem_y_data;
  logic                  mem_y_valid;
  logic                  mem_y_ready;
  logic [N_COL-1:0]      valid_y_in_sop;
  logic [DATA_WIDTH-1:0] y_in;
  logic                  valid_y_in;
  logic                  sum_over_constant;
  logic                  col_stall;

  modport master (
    input  mem_y_data, mem_y_valid, valid_y_in_sop,
    output mem_y_ready, y_in, valid_y_in, sum_over_constant, col_stall
  );

  modport slave (
    output mem_y_data, mem_y_valid, valid_y_in_sop,
    input  mem_y_ready, y_in, valid_y_in, sum_over_constant, col_stall
  );
endinterface

// File: rtl/hwce_yin_feeder.sv
// Accumulation-operand feeder for hwce_shift_adder. Buffers previous partial
// sums fetched from memory and releases one NPX-pixel vector each time all
// column engines present a valid sop. On a first input-channel pass nothing
// is fetched and the bias constant is selected instead.
// Ports:
//   clk, rst_n (sync, active-low), clear (soft clear, same effect as reset)
//   cfg_start, cfg_nb_vec, cfg_first_pass : pass configuration, sampled at start
//   bus (hwce_yin_feeder_if.master)       : memory stream + operand + stall
//   busy, done                            : pass status, done is a 1-cycle pulse
//   perf_stall_cnt                        : stall-cycle counter
// Optional feature: define HWCE_FEEDER_PERF_CNT_EN to build the stall counter;
// without it perf_stall_cnt is tied to 0.
//
// state    | meaning
// ST_IDLE  | waiting for cfg_start
// ST_RUN   | pass in progress, fetching and releasing vectors
// ST_DONE  | one-cycle end-of-pass pulse
module hwce_yin_feeder #(
  parameter int CONV_WIDTH = 16,
  parameter int NPX        = 2,
  parameter int N_COL      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 cfg_start,
  input  logic [CNT_WIDTH-1:0] cfg_nb_vec,
  input  logic                 cfg_first_pass,
  hwce_yin_feeder_if.master    bus,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          perf_stall_cnt
);
  localparam int DW = NPX * CONV_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] nb_vec, fetch_cnt, cons_cnt;
  logic                 first_pass;

  logic [DW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          fill;
  logic                 empty, full;

  logic                 run, start_acc, push, pop, fire, all_sop;
  logic                 ready_c, valid_c, soc_c, stall_c;
  logic [DW-1:0]        y_c;

  assign empty   = (fill == '0);
  assign full    = (fill == (PW+1)'(FIFO_DEPTH));
  assign all_sop = &bus.valid_y_in_sop;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state      <= ST_IDLE;
      nb_vec     <= '0;
      first_pass <= 1'b0;
      fetch_cnt  <= '0;
      cons_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        nb_vec     <= cfg_nb_vec;
        first_pass <= cfg_first_pass;
        fetch_cnt  <= '0;
        cons_cnt   <= '0;
      end else begin
        if (push) fetch_cnt <= fetch_cnt + 1'b1;
        if (fire) cons_cnt  <= cons_cnt + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Storage needs no reset: the operand is gated to 0 outside a streamed pass.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_y_data;
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    start_acc = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ready_c   = 1'b0;
    valid_c   = 1'b0;
    soc_c     = 1'b0;
    stall_c   = 1'b0;
    y_c       = '0;
    push      = 1'b0;
    pop       = 1'b0;
    fire      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          start_acc = 1'b1;
          state_nxt = (cfg_nb_vec == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        run     = 1'b1;
        busy    = 1'b1;
        soc_c   = first_pass;
        ready_c = !first_pass && !full && (fetch_cnt < nb_vec);
        valid_c = first_pass || !empty;
        y_c     = first_pass ? '0 : fifo_mem[rd_ptr];
        stall_c = all_sop && !valid_c;
        fire    = valid_c && all_sop;
        pop     = fire && !first_pass;
        // Full blocks a push even when a pop frees a slot this cycle.
        push    = bus.mem_y_valid && ready_c;
        if (fire && ((cons_cnt + 1'b1) == nb_vec)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.mem_y_ready       = ready_c;
  assign bus.valid_y_in        = valid_c;
  assign bus.sum_over_constant = soc_c;
  assign bus.col_stall         = stall_c;
  assign bus.y_in              = y_c;

`ifdef HWCE_FEEDER_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear || start_acc) begin
      stall_cnt <= '0;
    end else if (stall_c && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = 32'd0;
`endif

  logic unused_run;
  assign unused_run = run;
endmodule

// File: tb/tb_hwce_yin_feeder.sv
// Directed bench for hwce_yin_feeder: constant pass, streamed pass, late
// memory, full FIFO, zero-length pass, partial sop, ignored start, soft clear.
module tb_hwce_yin_feeder;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst_n, clear, cfg_start, cfg_first_pass;
  logic [15:0] cfg_nb_vec;
  logic        busy, done;
  logic [31:0] perf_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] beats [4] = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008};

  hwce_yin_feeder_if #(.DATA_WIDTH(DW), .N_COL(4)) bus ();

  hwce_yin_feeder #(
    .CONV_WIDTH(16), .NPX(2), .N_COL(4), .FIFO_DEPTH(8), .CNT_WIDTH(16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .cfg_start      (cfg_start),
    .cfg_nb_vec     (cfg_nb_vec),
    .cfg_first_pass (cfg_first_pass),
    .bus            (bus.master),
    .busy           (busy),
    .done           (done),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_ready"}, bus.mem_y_ready, 0);
    chk({tag, "_valid"}, bus.valid_y_in, 0);
    chk({tag, "_yin"},   bus.y_in, 0);
    chk({tag, "_soc"},   bus.sum_over_constant, 0);
    chk({tag, "_stall"}, bus.col_stall, 0);
    chk({tag, "_perf"},  perf_stall_cnt, 0);
  endtask

  task automatic start_pass(input logic [15:0] nb, input logic fp);
    cfg_nb_vec     = nb;
    cfg_first_pass = fp;
    cfg_start      = 1'b1;
    next_cyc;
    cfg_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, fires;
    logic got_done;
    logic [31:0] exp_perf;
`ifdef HWCE_FEEDER_PERF_CNT_EN
    exp_perf = 32'd5;
`else
    exp_perf = 32'd0;
`endif
    rst_n = 1'b0; clear = 1'b0; cfg_start = 1'b0; cfg_nb_vec = '0; cfg_first_pass = 1'b0;
    bus.mem_y_data = '0; bus.mem_y_valid = 1'b0; bus.valid_y_in_sop = '0;
    next_cyc; next_cyc;
    smp; chk_quiet("rst");
    next_cyc;
    rst_n = 1'b1;
    next_cyc;

    // Constant pass with partial sop and a start pulse during RUN.
    cfg_nb_vec = 16'd3; cfg_first_pass = 1'b1; cfg_start = 1'b1;
    smp; chk("c_idle_busy", busy, 0);
    next_cyc;
    cfg_nb_vec = 16'd1; cfg_first_pass = 1'b0; cfg_start = 1'b1;
    bus.valid_y_in_sop = 4'b0111;
    smp;
    chk("c_busy", busy, 1);
    chk("c_valid", bus.valid_y_in, 1);
    chk("c_soc", bus.sum_over_constant, 1);
    chk("c_ready", bus.mem_y_ready, 0);
    chk("c_yin", bus.y_in, 0);
    chk("c_partial_stall", bus.col_stall, 0);
    next_cyc;
    cfg_start = 1'b0; bus.valid_y_in_sop = 4'hF;
    smp; chk("c_soc_kept", bus.sum_over_constant, 1); chk("c_busy_f1", busy, 1);
    next_cyc; smp; chk("c_busy_f2", busy, 1);
    next_cyc; smp; chk("c_busy_f3", busy, 1);
    next_cyc;
    bus.valid_y_in_sop = '0;
    smp;
    chk("c_done", done, 1);
    chk("c_done_busy", busy, 0);
    chk("c_done_valid", bus.valid_y_in, 0);
    chk("c_done_soc", bus.sum_over_constant, 0);
    next_cyc; smp; chk("c_done_pulse", done, 0);
    next_cyc;

    // Streamed pass, back-to-back beats.
    start_pass(16'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.mem_y_valid = 1'b1; bus.mem_y_data = beats[i];
      smp;
      chk("s_ready", bus.mem_y_ready, 1);
      if (i == 0) chk("s_nobypass", bus.valid_y_in, 0);
      next_cyc;
    end
    smp;
    chk("s_ready_drop", bus.mem_y_ready, 0);
    chk("s_valid", bus.valid_y_in, 1);
    chk("s_soc", bus.sum_over_constant, 0);
    next_cyc;
    bus.mem_y_valid = 1'b0; bus.valid_y_in_sop = 4'hF;
    for (int i = 0; i < 4; i++) begin
      smp;
      chk("s_yin", bus.y_in, beats[i]);
      chk("s_valid_f", bus.valid_y_in, 1);
      next_cyc;
    end
    smp; chk("s_done", done, 1);
    next_cyc;
    bus.valid_y_in_sop = '0;

    // Late memory: five stalled cycles, then one beat.
    start_pass(16'd1, 1'b0);
    bus.valid_y_in_sop = 4'hF; bus.mem_y_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp; chk("l_stall", bus.col_stall, 1);
      next_cyc;
    end
    bus.mem_y_valid = 1'b1; bus.mem_y_data = 32'hAAAA_5555;
    smp; chk("l_stall_push", bus.col_stall, 1); chk("l_ready", bus.mem_y_ready, 1);
    next_cyc;
    bus.mem_y_valid = 1'b0;
    smp;
    chk("l_valid", bus.valid_y_in, 1);
    chk("l_yin", bus.y_in, 32'hAAAA_5555);
    chk("l_nostall", bus.col_stall, 0);
    next_cyc;
    smp; chk("l_done", done, 1); chk("l_perf", perf_stall_cnt, exp_perf);
    next_cyc;
    bus.valid_y_in_sop = '0;

    // Full FIFO with nb_vec=12.
    start_pass(16'd12, 1'b0);
    acc = 0;
    bus.mem_y_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.mem_y_data = 32'h100 + acc;
      smp;
      if (bus.mem_y_ready) acc++;
      next_cyc;
    end
    smp; chk("f_acc", acc, 8); chk("f_ready_full", bus.mem_y_ready, 0);
    next_cyc;
    bus.valid_y_in_sop = 4'hF;
    smp; chk("f_head", bus.y_in, 32'h100); chk("f_ready_pop", bus.mem_y_ready, 0);
    next_cyc;
    bus.valid_y_in_sop = '0;
    smp; chk("f_ready_after", bus.mem_y_ready, 1);
    if (bus.mem_y_ready) acc++;
    fires = 1;
    next_cyc;
    bus.valid_y_in_sop = 4'hF;
    got_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.mem_y_data = 32'h100 + acc;
      smp;
      if (done) got_done = 1'b1;
      if (bus.mem_y_ready) acc++;
      if (bus.valid_y_in) begin
        chk("f_order", bus.y_in, 32'h100 + fires);
        fires++;
      end
      next_cyc;
    end
    chk("f_done", got_done, 1);
    chk("f_total", acc, 12);
    chk("f_fires", fires, 12);
    bus.mem_y_valid = 1'b0; bus.valid_y_in_sop = '0;

    // Zero-length pass.
    cfg_nb_vec = 16'd0; cfg_first_pass = 1'b0; cfg_start = 1'b1; bus.mem_y_valid = 1'b1;
    smp; chk("z_ready_idle", bus.mem_y_ready, 0);
    next_cyc;
    cfg_start = 1'b0;
    smp; chk("z_done", done, 1); chk("z_busy", busy, 0); chk("z_ready", bus.mem_y_ready, 0);
    next_cyc;
    smp; chk("z_done_pulse", done, 0);
    next_cyc;
    bus.mem_y_valid = 1'b0;

    // Soft clear with three entries stored, then a fresh pass.
    start_pass(16'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.mem_y_valid = 1'b1; bus.mem_y_data = 32'h5000 + i;
      smp; chk("k_ready", bus.mem_y_ready, 1);
      next_cyc;
    end
    bus.mem_y_valid = 1'b0;
    smp; chk("k_valid", bus.valid_y_in, 1);
    next_cyc;
    clear = 1'b1;
    next_cyc;
    clear = 1'b0;
    smp; chk_quiet("clr");
    next_cyc;
    start_pass(16'd1, 1'b0);
    bus.mem_y_valid = 1'b1; bus.mem_y_data = 32'hDEAD_BEEF; bus.valid_y_in_sop = 4'hF;
    smp; chk("k2_stall", bus.col_stall, 1); chk("k2_empty", bus.valid_y_in, 0);
    next_cyc;
    bus.mem_y_valid = 1'b0;
    smp; chk("k2_yin", bus.y_in, 32'hDEAD_BEEF); chk("k2_valid", bus.valid_y_in, 1);
    next_cyc;
    smp; chk("k2_done", done, 1);
    next_cyc;
    bus.valid_y_in_sop = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
